// File: rtl/rca_nibble_seq.sv
// Multi-nibble add sequencer: a WIDTH-bit add is walked 4 bits per cycle through
// one rca_4bit, with the carry held in a register between nibbles.

module rca_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
endmodule

module rca_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [IW-1:0]     r_idx;
    logic [WIDTH-5:0]  r_acc;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [3:0]        w_nib_sum;
    logic              w_nib_cout;
    logic              w_last;
    logic              w_accept;

    assign w_last   = (r_idx == LAST_IDX);
    assign w_accept = (r_state == S_IDLE) && in_valid;

    always_comb begin
        w_a_nib = 4'h0;
        w_b_nib = 4'h0;
        for (int k = 0; k < NIB; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_nib = r_a[4*k +: 4];
                w_b_nib = r_b[4*k +: 4];
            end
        end
    end

    rca_4bit u_rca (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // The top nibble never lands in r_acc; it goes straight into the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_acc   <= '0;
        end else if (r_state == S_RUN) begin
            for (int k = 0; k < NIB - 1; k++) begin
                if (r_idx == IW'(k)) begin
                    r_acc[4*k +: 4] <= w_nib_sum;
                end
            end
            r_carry <= w_nib_cout;
            r_idx   <= r_idx + IW'(1);
            if (w_last) begin
                r_idx  <= '0;
                r_sum  <= {w_nib_sum, r_acc};
                r_cout <= w_nib_cout;
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_nib_sum[3] != r_a[WIDTH-1]);
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_rca_nibble_seq.sv
// Self-checking bench for rca_nibble_seq at WIDTH=16, 8 and 32, checked against
// a plain a+b+cin arithmetic model.

module tb_rca_nibble_seq;
    logic clk;
    logic rst;

    logic        iv16, ir16, ov16, or16, cin16, co16, ovf16, busy16;
    logic [15:0] a16, b16, sum16;
    logic        iv8, ir8, ov8, or8, cin8, co8, ovf8, busy8;
    logic [7:0]  a8, b8, sum8;
    logic        iv32, ir32, ov32, or32, cin32, co32, ovf32, busy32;
    logic [31:0] a32, b32, sum32;

    int errors = 0;
    int checks = 0;

    rca_nibble_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
        .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(co16), .ovf(ovf16), .busy(busy16));
    rca_nibble_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(co8), .ovf(ovf8), .busy(busy8));
    rca_nibble_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32),
        .out_valid(ov32), .out_ready(or32), .sum(sum32), .cout(co32), .ovf(ovf32), .busy(busy32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // {ovf, cout, sum} from the arithmetic definition
    function automatic logic [17:0] model16(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
        logic [16:0] full;
        logic        v;
        full = {1'b0, ta} + {1'b0, tb} + {16'h0, tc};
        v    = (ta[15] == tb[15]) && (full[15] != ta[15]);
        return {v, full};
    endfunction

    task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                           input string nm, input bit hold);
        logic [17:0] exp;
        exp = model16(ta, tb, tc);
        @(negedge clk);
        checks++;
        if (ir16 !== 1'b1) begin
            errors++; $display("FAIL %s in_ready before accept: got %b expected 1", nm, ir16);
        end
        a16 = ta; b16 = tb; cin16 = tc; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ov16 !== (k == 4)) begin
                errors++; $display("FAIL %s out_valid after edge T+%0d: got %b expected %b", nm, k, ov16, (k == 4));
            end
        end
        checks++;
        if ({ovf16, co16, sum16} !== exp) begin
            errors++; $display("FAIL %s result {ovf,cout,sum}: got %b,%b,%h expected %b,%b,%h",
                               nm, ovf16, co16, sum16, exp[17], exp[16], exp[15:0]);
        end
        if (!hold) begin
            or16 = 1'b1;
            @(posedge clk); #1;
            or16 = 1'b0;
            checks++;
            if ({ov16, ir16, busy16} !== 3'b010) begin
                errors++; $display("FAIL %s release {out_valid,in_ready,busy}: got %b expected 010", nm, {ov16, ir16, busy16});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({sum16, co16, ovf16, ov16, busy16} !== 20'h0) begin
            errors++; $display("FAIL reset outputs16: got sum=%h cout=%b ovf=%b ov=%b busy=%b expected all 0",
                               sum16, co16, ovf16, ov16, busy16);
        end
        checks++;
        if ({sum8, co8, ovf8, ov8, busy8, sum32, co32, ovf32, ov32, busy32} !== 52'h0) begin
            errors++; $display("FAIL reset outputs8/32: got sum8=%h sum32=%h flags8=%b flags32=%b expected 0",
                               sum8, sum32, {co8, ovf8, ov8, busy8}, {co32, ovf32, ov32, busy32});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({ir16, ir8, ir32} !== 3'b111) begin
            errors++; $display("FAIL reset in_ready after release: got %b expected 111", {ir16, ir8, ir32});
        end
    endtask

    task automatic test_directed();
        do_op16(16'hFFFF, 16'h0001, 1'b0, "ffff_plus_1", 1'b0);
        do_op16(16'h7FFF, 16'h0001, 1'b0, "pos_ovf", 1'b0);
        do_op16(16'h8000, 16'h8000, 1'b0, "neg_ovf", 1'b0);
        do_op16(16'h1234, 16'h4321, 1'b1, "cin_1234", 1'b0);
        do_op16(16'h0000, 16'h0000, 1'b1, "cin_only", 1'b0);
    endtask

    task automatic test_backpressure();
        logic [17:0] held;
        do_op16(16'h9000, 16'h9000, 1'b0, "bp_op", 1'b1);
        held = {ovf16, co16, sum16};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a16 = 16'h0101; b16 = 16'h0202; cin16 = 1'b0; iv16 = 1'b1;
            end else begin
                iv16 = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if ({ov16, ir16, ovf16, co16, sum16} !== {1'b1, 1'b0, 18'h32000}) begin
                errors++; $display("FAIL backpressure hold cycle %0d: got ov=%b ir=%b ovf=%b cout=%b sum=%h expected 1,0,1,1,2000",
                                   c, ov16, ir16, ovf16, co16, sum16);
            end
        end
        iv16 = 1'b0;
        @(negedge clk);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        checks++;
        if ({ov16, ir16, ovf16, co16, sum16} !== {2'b01, held}) begin
            errors++; $display("FAIL backpressure release: got ov=%b ir=%b result=%h expected 0,1,%h",
                               ov16, ir16, {ovf16, co16, sum16}, held);
        end
        @(posedge clk); #1;
        checks++;
        if (busy16 !== 1'b0) begin
            errors++; $display("FAIL backpressure ignored pulse: busy got %b expected 0", busy16);
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        a16 = 16'h0F0F; b16 = 16'h1111; cin16 = 1'b1; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({sum16, co16, ovf16, ov16, busy16} !== 20'h0) begin
            errors++; $display("FAIL midrun reset: got sum=%h cout=%b ovf=%b ov=%b busy=%b expected all 0",
                               sum16, co16, ovf16, ov16, busy16);
        end
        #2;
        rst = 1'b0;
        do_op16(16'h00FF, 16'h0001, 1'b0, "after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [17:0] q[$];
        logic [17:0] exp;
        int acc_t[3];
        int n_acc, n_res, cyc;
        bit acc_now;
        n_acc = 0; n_res = 0; cyc = 0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        iv16 = 1'b1; or16 = 1'b1;
        while (n_res < 3 && cyc < 60) begin
            @(negedge clk);
            acc_now = 1'b0;
            if (iv16 && ir16) begin
                acc_t[n_acc] = cyc;
                q.push_back(model16(a16, b16, cin16));
                acc_now = 1'b1;
            end
            if (ov16) begin
                exp = (q.size() > 0) ? q.pop_front() : 18'h0;
                checks++;
                if ({ovf16, co16, sum16} !== exp) begin
                    errors++; $display("FAIL b2b result %0d: got %h expected %h", n_res, {ovf16, co16, sum16}, exp);
                end
                n_res++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                n_acc++;
                if (n_acc < 3) begin
                    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
                end else begin
                    iv16 = 1'b0;
                end
            end
        end
        iv16 = 1'b0; or16 = 1'b0;
        checks++;
        if (n_res != 3 || n_acc != 3) begin
            errors++; $display("FAIL b2b completion: got %0d results %0d accepts expected 3 and 3", n_res, n_acc);
        end else begin
            checks++;
            if (acc_t[1] - acc_t[0] != 6 || acc_t[2] - acc_t[1] != 6) begin
                errors++; $display("FAIL b2b spacing: got %0d,%0d expected 6,6", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
            end
        end
    endtask

    task automatic test_random16();
        for (int i = 0; i < 12; i++) begin
            do_op16(16'($urandom), 16'($urandom), 1'($urandom), "rand16", 1'b0);
        end
    endtask

    task automatic test_width8();
        logic [7:0] ta, tb;
        logic       tc, ev;
        logic [8:0] full;
        int cnt;
        for (int i = 0; i < 25; i++) begin
            ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom);
            full = {1'b0, ta} + {1'b0, tb} + {8'h0, tc};
            ev   = (ta[7] == tb[7]) && (full[7] != ta[7]);
            @(negedge clk);
            a8 = ta; b8 = tb; cin8 = tc; iv8 = 1'b1;
            @(posedge clk); #1;
            iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            cnt = 0;
            while (!ov8 && cnt < 10) begin
                @(posedge clk); #1;
                cnt++;
            end
            checks++;
            if (cnt != 2) begin
                errors++; $display("FAIL w8 latency op %0d: got %0d edges expected 2", i, cnt);
            end
            checks++;
            if ({ev, full} !== {ovf8, co8, sum8}) begin
                errors++; $display("FAIL w8 result op %0d: got %h expected %h", i, {ovf8, co8, sum8}, {ev, full});
            end
            or8 = 1'b1;
            @(posedge clk); #1;
            or8 = 1'b0;
        end
    endtask

    task automatic test_width32();
        logic [31:0] ta, tb;
        logic        tc, ev;
        logic [32:0] full;
        int cnt;
        for (int i = 0; i < 25; i++) begin
            ta = $urandom; tb = $urandom; tc = 1'($urandom);
            if (i == 0) begin ta = 32'hFFFF_FFFF; tb = 32'h0; tc = 1'b1; end
            if (i == 1) begin ta = 32'h7FFF_FFFF; tb = 32'h7FFF_FFFF; tc = 1'b1; end
            full = {1'b0, ta} + {1'b0, tb} + {32'h0, tc};
            ev   = (ta[31] == tb[31]) && (full[31] != ta[31]);
            @(negedge clk);
            a32 = ta; b32 = tb; cin32 = tc; iv32 = 1'b1;
            @(posedge clk); #1;
            iv32 = 1'b0; a32 = $urandom; b32 = $urandom;
            cnt = 0;
            while (!ov32 && cnt < 16) begin
                @(posedge clk); #1;
                cnt++;
            end
            checks++;
            if (cnt != 8) begin
                errors++; $display("FAIL w32 latency op %0d: got %0d edges expected 8", i, cnt);
            end
            checks++;
            if ({ev, full} !== {ovf32, co32, sum32}) begin
                errors++; $display("FAIL w32 result op %0d: got %h expected %h", i, {ovf32, co32, sum32}, {ev, full});
            end
            or32 = 1'b1;
            @(posedge clk); #1;
            or32 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        iv8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
        iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        test_random16();
        test_width8();
        test_width32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
